// File: rtl/tia_pkg.sv
// Shared TIA definitions: object indices, HMOVE sequencer states and timing constants.
package tia_pkg;

  typedef enum logic [2:0] {
    OBJ_P0 = 3'd0,
    OBJ_P1,
    OBJ_M0,
    OBJ_M1,
    OBJ_BL
  } obj_e;

  typedef enum logic {
    HM_IDLE = 1'b0,
    HM_RUN  = 1'b1
  } hm_state_e;

  localparam int unsigned HM_STEPS         = 16;
  localparam int unsigned LATE_HBLANK_CLKS = 8;

  // Step at which an object's latch drops; an object gets this many extra clocks.
  function automatic logic [3:0] hm_match_step(input logic [3:0] hm);
    return hm ^ 4'b1000;
  endfunction

endpackage

// File: rtl/hmove_obj_latch.sv
// Per-object HMOVE motion latch: compares the live motion nibble against the
// current step and emits a registered one-clk extra-clock pulse.
module hmove_obj_latch
  import tia_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       eval,
  input  logic       last_step,
  input  logic [3:0] step,
  input  logic [3:0] hm,
  output logic       extra_clk
);

  logic latch_q, latch_d;
  logic extra_q, extra_d;

  always_comb begin
    latch_d = latch_q;
    extra_d = 1'b0;
    if (start) begin
      latch_d = 1'b1;
    end else if (eval && latch_q) begin
      // The final step never pulses: it either matches or force-clears the latch.
      if (step == hm_match_step(hm) || last_step) begin
        latch_d = 1'b0;
      end else begin
        extra_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q <= 1'b0;
      extra_q <= 1'b0;
    end else begin
      latch_q <= latch_d;
      extra_q <= extra_d;
    end
  end

  assign extra_clk = extra_q;

endmodule

// File: rtl/hmove_sequencer.sv
// HMOVE horizontal-motion sequencer: 16-step extra-clock generator for the five
// TIA object counters plus the 8-color-clock late-HBLANK extension.
module hmove_sequencer
  import tia_pkg::*;
#(
  parameter int unsigned NUM_OBJ   = 5,
  parameter int unsigned STEP_CLKS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   hmove,
  input  logic [4*NUM_OBJ-1:0]   hm,
  input  logic                   hblank,
  output logic [NUM_OBJ-1:0]     extra_clk,
  output logic                   hmove_active,
  output logic                   late_hblank
);

  localparam int unsigned     PH_W      = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam int unsigned     LC_W      = $clog2(LATE_HBLANK_CLKS + 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(STEP_CLKS - 1);
  localparam logic [3:0]      STEP_LAST = 4'(HM_STEPS - 1);
  localparam logic [LC_W-1:0] LATE_LOAD = LC_W'(LATE_HBLANK_CLKS);

  hm_state_e       state_q, state_d;
  logic [3:0]      step_q, step_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            hmove_line_q, hmove_line_d;
  logic            hblank_q, hblank_d;
  logic [LC_W-1:0] late_cnt_q, late_cnt_d;

  logic start, eval, last_step, hb_rise, hb_fall;

  assign start     = ce & hmove;
  assign eval      = ce & ~hmove & (state_q == HM_RUN) & (phase_q == PH_LAST);
  assign last_step = (step_q == STEP_LAST);
  assign hb_rise   = ce & hblank & ~hblank_q;
  assign hb_fall   = ce & ~hblank & hblank_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = phase_q;
    if (start) begin
      state_d = HM_RUN;
      step_d  = '0;
      phase_d = '0;
    end else if (ce && state_q == HM_RUN) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        if (last_step) begin
          state_d = HM_IDLE;
          step_d  = '0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  always_comb begin
    hblank_d     = ce ? hblank : hblank_q;
    hmove_line_d = hmove_line_q;
    late_cnt_d   = late_cnt_q;
    // A strobe on the hblank rising edge keeps the line marked.
    if (start) begin
      hmove_line_d = 1'b1;
    end else if (hb_rise) begin
      hmove_line_d = 1'b0;
    end
    if (hb_rise) begin
      late_cnt_d = '0;
    end else if (hb_fall && hmove_line_q) begin
      late_cnt_d = LATE_LOAD;
    end else if (ce && late_cnt_q != '0) begin
      late_cnt_d = late_cnt_q - LC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HM_IDLE;
      step_q       <= '0;
      phase_q      <= '0;
      hmove_line_q <= 1'b0;
      hblank_q     <= 1'b0;
      late_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      phase_q      <= phase_d;
      hmove_line_q <= hmove_line_d;
      hblank_q     <= hblank_d;
      late_cnt_q   <= late_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
    hmove_obj_latch u_latch (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .eval      (eval),
      .last_step (last_step),
      .step      (step_q),
      .hm        (hm[4*gi +: 4]),
      .extra_clk (extra_clk[gi])
    );
  end

  assign hmove_active = (state_q == HM_RUN);
  assign late_hblank  = (late_cnt_q != '0);

endmodule
